// File: rtl/rxd2fifoc_pkg.sv
// rtl/rxd2fifoc_pkg.sv - shared constants, state encoding and helpers for rxd2fifoc
package rxd2fifoc_pkg;

  // Must stay identical to the parser's 16'h55AA header check.
  localparam logic [7:0]  HDR_B0      = 8'h55;
  localparam logic [7:0]  HDR_B1      = 8'hAA;
  localparam logic [11:0] MIN_LEN     = 12'd3;
  localparam logic [11:0] MAX_LEN_DEF = 12'd32;
  localparam logic [15:0] TIMEOUT_DEF = 16'd50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDRW,
    ST_BODY,
    ST_HAND,
    ST_REL,
    ST_FLSH
  } state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/rxd2fifoc_if.sv
// rtl/rxd2fifoc_if.sv - byte receiver / fifoc / parser signal bundle for rxd2fifoc
interface rxd2fifoc_if;
  import rxd2fifoc_pkg::*;

  logic        rxd_vld;
  logic [7:0]  rxd;
  logic [11:0] data_len;
  logic        fifoc_full;
  logic        fifoc_txen;
  logic [7:0]  fifoc_txd;
  logic        fifoc_clr;
  logic        fs;
  logic        fd;
  logic        err;
  logic [7:0]  frame_cnt;
  logic [7:0]  drop_cnt;

  modport slave (
    input  rxd_vld, rxd, data_len, fifoc_full, fd,
    output fifoc_txen, fifoc_txd, fifoc_clr, fs, err, frame_cnt, drop_cnt
  );

  modport master (
    output rxd_vld, rxd, data_len, fifoc_full, fd,
    input  fifoc_txen, fifoc_txd, fifoc_clr, fs, err, frame_cnt, drop_cnt
  );

endinterface

// File: rtl/rxd2fifoc_gap_timer.sv
// rtl/rxd2fifoc_gap_timer.sv - inter-byte gap timer, saturates at TIMEOUT
module rxd2fifoc_gap_timer
  import rxd2fifoc_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 16'd0;
    end else if (en_i && (cnt_q != TIMEOUT)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == TIMEOUT);

endmodule

// File: rtl/rxd2fifoc.sv
// rtl/rxd2fifoc.sv - hunts 0x55AA in the rx byte stream and loads one frame into fifoc
module rxd2fifoc
  import rxd2fifoc_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF,
  parameter logic [11:0] MAX_LEN = MAX_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  rxd2fifoc_if.slave    bus
);

  state_e      state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [11:0] cnt_q, cnt_d;
  logic        txen_q, txen_d;
  logic [7:0]  txd_q, txd_d;
  logic        fs_q, fs_d;
  logic        err_q, err_d;
  logic [7:0]  frame_q, frame_d;
  logic [7:0]  drop_q, drop_d;
  logic [1:0]  drop_inc;

  logic        vld;
  logic        len_ok;
  logic        ovf;
  logic        expired;
  logic        tmr_clr;
  logic        tmr_en;

  assign vld    = bus.rxd_vld;
  assign len_ok = (bus.data_len >= MIN_LEN) && (bus.data_len <= MAX_LEN);
  // A write still on the fifoc port while it reports full is lost, so the frame is too.
  assign ovf    = txen_q && bus.fifoc_full;

  assign tmr_en  = (state_q == ST_SYNC) || (state_q == ST_BODY);
  assign tmr_clr = vld || (state_q == ST_IDLE) || (state_q == ST_HAND) ||
                   (state_q == ST_REL) || (state_q == ST_FLSH);

  rxd2fifoc_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    txen_d   = 1'b0;
    txd_d    = txd_q;
    fs_d     = fs_q;
    err_d    = err_q;
    frame_d  = frame_q;
    drop_inc = 2'd0;

    case (state_q)
      ST_IDLE: begin
        if (vld) begin
          if (bus.rxd == HDR_B0) begin
            state_d = ST_SYNC;
          end else begin
            drop_inc = 2'd1;
          end
        end
      end

      ST_SYNC: begin
        if (vld) begin
          if (bus.rxd == HDR_B1) begin
            len_d = bus.data_len;
            if (len_ok) begin
              txen_d  = 1'b1;
              txd_d   = HDR_B0;
              err_d   = 1'b0;
              state_d = ST_HDRW;
            end else begin
              err_d    = 1'b1;
              drop_inc = 2'd2;
              state_d  = ST_IDLE;
            end
          end else if (bus.rxd == HDR_B0) begin
            // Repeated 0x55: the older one is discarded, the newer one may still start a header.
            drop_inc = 2'd1;
          end else begin
            drop_inc = 2'd2;
            state_d  = ST_IDLE;
          end
        end else if (expired) begin
          drop_inc = 2'd1;
          state_d  = ST_IDLE;
        end
      end

      ST_HDRW: begin
        if (vld) begin
          drop_inc = 2'd1;
        end
        if (ovf) begin
          state_d = ST_FLSH;
        end else begin
          txen_d  = 1'b1;
          txd_d   = HDR_B1;
          cnt_d   = 12'd2;
          state_d = ST_BODY;
        end
      end

      ST_BODY: begin
        if (ovf || expired) begin
          if (vld) begin
            drop_inc = 2'd1;
          end
          state_d = ST_FLSH;
        end else if (vld) begin
          txen_d = 1'b1;
          txd_d  = bus.rxd;
          if (cnt_q == (len_q - 12'd1)) begin
            state_d = ST_HAND;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end

      ST_HAND: begin
        if (vld) begin
          drop_inc = 2'd1;
        end
        // fs only rises after the last byte has left the write port, so that write's
        // overflow is still caught here before the parser is started.
        if (ovf) begin
          fs_d    = 1'b0;
          state_d = ST_FLSH;
        end else if (fs_q && bus.fd) begin
          fs_d    = 1'b0;
          frame_d = frame_q + 8'd1;
          state_d = ST_REL;
        end else begin
          fs_d = 1'b1;
        end
      end

      ST_REL: begin
        if (vld) begin
          drop_inc = 2'd1;
        end
        if (!bus.fd) begin
          state_d = ST_IDLE;
        end
      end

      ST_FLSH: begin
        if (vld) begin
          drop_inc = 2'd1;
        end
        err_d   = 1'b1;
        cnt_d   = 12'd0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    drop_d = sat_add8(drop_q, drop_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= 12'd0;
      cnt_q   <= 12'd0;
      txen_q  <= 1'b0;
      txd_q   <= 8'd0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
      frame_q <= 8'd0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      txen_q  <= txen_d;
      txd_q   <= txd_d;
      fs_q    <= fs_d;
      err_q   <= err_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.fifoc_txen = txen_q;
  assign bus.fifoc_txd  = txd_q;
  assign bus.fifoc_clr  = (state_q == ST_FLSH);
  assign bus.fs         = fs_q;
  assign bus.err        = err_q;
  assign bus.frame_cnt  = frame_q;
  assign bus.drop_cnt   = drop_q;

endmodule
